// File: rtl/cluster_serializer.sv
// cluster_serializer: captures a sorted set of eight clusters on latch_pulse
// and serializes them two per cycle over four slot cycles (SEND0..SEND3).
// Optional feature: define VALID_COUNT_EN to register the number of valid
// clusters per capture on nvalid; otherwise nvalid is tied to zero.
module cluster_serializer #(
    parameter int MXADRBITS = 11,
    parameter int MXCNTBITS = 3,
    parameter int MXFRMBITS = 12
) (
    input  logic                           clock4x,
    input  logic                           reset,
    input  logic                           latch_pulse,
    input  logic [MXADRBITS-1:0]           adr0,
    input  logic [MXADRBITS-1:0]           adr1,
    input  logic [MXADRBITS-1:0]           adr2,
    input  logic [MXADRBITS-1:0]           adr3,
    input  logic [MXADRBITS-1:0]           adr4,
    input  logic [MXADRBITS-1:0]           adr5,
    input  logic [MXADRBITS-1:0]           adr6,
    input  logic [MXADRBITS-1:0]           adr7,
    input  logic [MXCNTBITS-1:0]           cnt0,
    input  logic [MXCNTBITS-1:0]           cnt1,
    input  logic [MXCNTBITS-1:0]           cnt2,
    input  logic [MXCNTBITS-1:0]           cnt3,
    input  logic [MXCNTBITS-1:0]           cnt4,
    input  logic [MXCNTBITS-1:0]           cnt5,
    input  logic [MXCNTBITS-1:0]           cnt6,
    input  logic [MXCNTBITS-1:0]           cnt7,
    output logic [MXADRBITS+MXCNTBITS-1:0] word0,
    output logic [MXADRBITS+MXCNTBITS-1:0] word1,
    output logic                           vld0,
    output logic                           vld1,
    output logic                           frame_start,
    output logic                           busy,
    output logic [MXFRMBITS-1:0]           frame_count,
    output logic                           collision,
    output logic [3:0]                     nvalid
);

    // All-ones address marks an empty cluster slot.
    localparam logic [MXADRBITS-1:0] ADR_INVALID = {MXADRBITS{1'b1}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND0 = 3'd1,
        SEND1 = 3'd2,
        SEND2 = 3'd3,
        SEND3 = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [MXADRBITS-1:0]   in_adr_s [8];
    logic [MXCNTBITS-1:0]   in_cnt_s [8];
    logic [MXADRBITS-1:0]   adr_q    [8];
    logic [MXCNTBITS-1:0]   cnt_q    [8];
    logic [MXFRMBITS-1:0]   frame_count_q;
    logic                   collision_q;
    logic                   abort_s;
    logic                   active_s;
    logic [1:0]             slot_s;
    logic [2:0]             lo_idx_s;
    logic [2:0]             hi_idx_s;

    assign in_adr_s[0] = adr0;
    assign in_adr_s[1] = adr1;
    assign in_adr_s[2] = adr2;
    assign in_adr_s[3] = adr3;
    assign in_adr_s[4] = adr4;
    assign in_adr_s[5] = adr5;
    assign in_adr_s[6] = adr6;
    assign in_adr_s[7] = adr7;
    assign in_cnt_s[0] = cnt0;
    assign in_cnt_s[1] = cnt1;
    assign in_cnt_s[2] = cnt2;
    assign in_cnt_s[3] = cnt3;
    assign in_cnt_s[4] = cnt4;
    assign in_cnt_s[5] = cnt5;
    assign in_cnt_s[6] = cnt6;
    assign in_cnt_s[7] = cnt7;

    // A capture before the last slot cycle abandons a frame in flight.
    assign abort_s = latch_pulse &&
                     ((state_q == SEND0) || (state_q == SEND1) || (state_q == SEND2));

    // State register.
    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a capture always restarts at SEND0, otherwise walk the slots.
    always_comb begin
        state_d = state_q;
        if (latch_pulse) begin
            state_d = SEND0;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                SEND0:   state_d = SEND1;
                SEND1:   state_d = SEND2;
                SEND2:   state_d = SEND3;
                SEND3:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Cluster buffer: load all eight pairs on capture, else hold.
    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                adr_q[i] <= ADR_INVALID;
                cnt_q[i] <= {MXCNTBITS{1'b0}};
            end
        end else if (latch_pulse) begin
            for (int i = 0; i < 8; i++) begin
                adr_q[i] <= in_adr_s[i];
                cnt_q[i] <= in_cnt_s[i];
            end
        end
    end

    // Capture counter (wraps) and sticky abort flag.
    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            frame_count_q <= {MXFRMBITS{1'b0}};
            collision_q   <= 1'b0;
        end else begin
            if (latch_pulse) begin
                frame_count_q <= frame_count_q + {{(MXFRMBITS-1){1'b0}}, 1'b1};
            end
            if (abort_s) begin
                collision_q <= 1'b1;
            end
        end
    end

    // Slot decode: which cluster pair the current state presents.
    always_comb begin
        active_s = 1'b0;
        slot_s   = 2'd0;
        case (state_q)
            SEND0:   begin active_s = 1'b1; slot_s = 2'd0; end
            SEND1:   begin active_s = 1'b1; slot_s = 2'd1; end
            SEND2:   begin active_s = 1'b1; slot_s = 2'd2; end
            SEND3:   begin active_s = 1'b1; slot_s = 2'd3; end
            default: begin active_s = 1'b0; slot_s = 2'd0; end
        endcase
    end

    assign lo_idx_s = {slot_s, 1'b0};
    assign hi_idx_s = {slot_s, 1'b1};

    // Word/valid outputs decode straight from the buffer; idle shows an empty pair.
    always_comb begin
        if (active_s) begin
            word0 = {cnt_q[lo_idx_s], adr_q[lo_idx_s]};
            word1 = {cnt_q[hi_idx_s], adr_q[hi_idx_s]};
            vld0  = (adr_q[lo_idx_s] != ADR_INVALID);
            vld1  = (adr_q[hi_idx_s] != ADR_INVALID);
        end else begin
            word0 = {{MXCNTBITS{1'b0}}, ADR_INVALID};
            word1 = {{MXCNTBITS{1'b0}}, ADR_INVALID};
            vld0  = 1'b0;
            vld1  = 1'b0;
        end
    end

    assign busy        = active_s;
    assign frame_start = (state_q == SEND0);
    assign frame_count = frame_count_q;
    assign collision   = collision_q;

`ifdef VALID_COUNT_EN
    logic [3:0] in_nvalid_s;
    logic [3:0] nvalid_q;

    // Population count of valid addresses on the capture inputs.
    always_comb begin
        in_nvalid_s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            in_nvalid_s = in_nvalid_s + {3'd0, (in_adr_s[i] != ADR_INVALID)};
        end
    end

    // Hold the valid count of the most recent capture.
    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            nvalid_q <= 4'd0;
        end else if (latch_pulse) begin
            nvalid_q <= in_nvalid_s;
        end
    end

    assign nvalid = nvalid_q;
`else
    assign nvalid = 4'd0;
`endif

endmodule

// File: tb/tb_cluster_serializer.sv
// Self-checking bench for cluster_serializer: directed scenarios plus random
// captures/resets compared against a slot-index reference model.
module tb_cluster_serializer;

    localparam logic [10:0] INV = 11'h7FF;

    logic        clock4x = 1'b0;
    logic        reset;
    logic        latch_pulse;
    logic [10:0] adr [8];
    logic [2:0]  cnt [8];
    logic [13:0] word0, word1;
    logic        vld0, vld1, frame_start, busy, collision;
    logic [11:0] frame_count;
    logic [3:0]  nvalid;

    // Reference model: captured frame, slot position (0..3 active, 4 idle)
    logic [10:0] m_adr [8];
    logic [2:0]  m_cnt [8];
    int          m_pos;
    logic [11:0] m_fc;
    logic        m_col;
    logic [3:0]  m_nv;

    int errors = 0;
    int checks = 0;

    always #5 clock4x = ~clock4x;

    cluster_serializer dut (
        .clock4x(clock4x), .reset(reset), .latch_pulse(latch_pulse),
        .adr0(adr[0]), .adr1(adr[1]), .adr2(adr[2]), .adr3(adr[3]),
        .adr4(adr[4]), .adr5(adr[5]), .adr6(adr[6]), .adr7(adr[7]),
        .cnt0(cnt[0]), .cnt1(cnt[1]), .cnt2(cnt[2]), .cnt3(cnt[3]),
        .cnt4(cnt[4]), .cnt5(cnt[5]), .cnt6(cnt[6]), .cnt7(cnt[7]),
        .word0(word0), .word1(word1), .vld0(vld0), .vld1(vld1),
        .frame_start(frame_start), .busy(busy), .frame_count(frame_count),
        .collision(collision), .nvalid(nvalid)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_adr[i] = INV;
            m_cnt[i] = 3'd0;
        end
        m_pos = 4;
        m_fc  = 12'd0;
        m_col = 1'b0;
        m_nv  = 4'd0;
    endtask

    // Apply the behavioural rules for one rising edge.
    task automatic model_edge();
        int n;
        if (!reset) begin
            if (latch_pulse) begin
                if (m_pos < 3) m_col = 1'b1;
                n = 0;
                for (int i = 0; i < 8; i++) begin
                    m_adr[i] = adr[i];
                    m_cnt[i] = cnt[i];
                    if (adr[i] != INV) n++;
                end
`ifdef VALID_COUNT_EN
                m_nv = 4'(n);
`else
                m_nv = 4'd0;
`endif
                m_fc  = m_fc + 12'd1;
                m_pos = 0;
            end else if (m_pos < 4) begin
                m_pos = m_pos + 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [13:0] e_w0, e_w1;
        logic        e_v0, e_v1;
        if (m_pos < 4) begin
            e_w0 = {m_cnt[2*m_pos], m_adr[2*m_pos]};
            e_w1 = {m_cnt[2*m_pos+1], m_adr[2*m_pos+1]};
            e_v0 = (m_adr[2*m_pos] != INV);
            e_v1 = (m_adr[2*m_pos+1] != INV);
        end else begin
            e_w0 = {3'd0, INV};
            e_w1 = {3'd0, INV};
            e_v0 = 1'b0;
            e_v1 = 1'b0;
        end
        check_val("word0", 32'(word0), 32'(e_w0));
        check_val("word1", 32'(word1), 32'(e_w1));
        check_val("vld0", 32'(vld0), 32'(e_v0));
        check_val("vld1", 32'(vld1), 32'(e_v1));
        check_val("frame_start", 32'(frame_start), 32'(m_pos == 0));
        check_val("busy", 32'(busy), 32'(m_pos < 4));
        check_val("frame_count", 32'(frame_count), 32'(m_fc));
        check_val("collision", 32'(collision), 32'(m_col));
        check_val("nvalid", 32'(nvalid), 32'(m_nv));
    endtask

    // One clock: update model at the edge, compare at the falling edge.
    task automatic step(input bit do_chk);
        @(posedge clock4x);
        model_edge();
        @(negedge clock4x);
        if (do_chk) check_outputs();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(negedge clock4x);
        reset = 1'b0;
    endtask

    task automatic rand_inputs(input int inv_pct);
        for (int i = 0; i < 8; i++) begin
            adr[i] = ($urandom_range(99) < inv_pct) ? INV : 11'($urandom_range(11'h7FE));
            cnt[i] = 3'($urandom);
        end
    endtask

    initial begin
        reset       = 1'b1;
        latch_pulse = 1'b0;
        for (int i = 0; i < 8; i++) begin
            adr[i] = INV;
            cnt[i] = 3'd0;
        end
        model_reset();
        @(negedge clock4x);
        check_outputs();
        // Captures under reset are ignored
        latch_pulse = 1'b1;
        rand_inputs(0);
        step(1);
        step(1);
        reset = 1'b0;
        latch_pulse = 1'b0;

        // Ascending addresses, cnt 1..7,0
        for (int i = 0; i < 8; i++) begin
            adr[i] = 11'(16 * (i + 1));
            cnt[i] = 3'((i + 1) % 8);
        end
        latch_pulse = 1'b1;
        step(1);
        latch_pulse = 1'b0;
        check_val("asc_w0", 32'(word0), 32'({3'd1, 11'h010}));
        check_val("asc_w1", 32'(word1), 32'({3'd2, 11'h020}));
        step(1);
        check_val("asc_w0_s1", 32'(word0), 32'({3'd3, 11'h030}));
        step(1);
        step(1);
        check_val("asc_w1_s3", 32'(word1), 32'({3'd0, 11'h080}));
        check_val("asc_vld", 32'({vld0, vld1, frame_start}), 32'(3'b110));
        step(1);
        check_val("asc_idle", 32'(busy), 32'd0);
        check_val("asc_fc", 32'(frame_count), 32'd1);

        // Only three valid clusters
        apply_reset();
        rand_inputs(0);
        for (int i = 3; i < 8; i++) adr[i] = INV;
        latch_pulse = 1'b1;
        step(1);
        latch_pulse = 1'b0;
        check_val("part_vld_s0", 32'({vld0, vld1}), 32'(2'b11));
`ifdef VALID_COUNT_EN
        check_val("part_nvalid", 32'(nvalid), 32'd3);
`else
        check_val("part_nvalid", 32'(nvalid), 32'd0);
`endif
        step(1);
        check_val("part_vld_s1", 32'({vld0, vld1}), 32'(2'b10));
        step(1);
        check_val("part_vld_s2", 32'({vld0, vld1}), 32'(2'b00));
        step(1);
        check_val("part_vld_s3", 32'({vld0, vld1}), 32'(2'b00));
        step(1);

        // Back-to-back frames: latch every 4th cycle
        apply_reset();
        for (int f = 0; f < 3; f++) begin
            rand_inputs(20);
            latch_pulse = 1'b1;
            step(1);
            latch_pulse = 1'b0;
            check_val("b2b_start", 32'({busy, frame_start}), 32'(2'b11));
            for (int k = 0; k < 3; k++) begin
                step(1);
                check_val("b2b_busy", 32'({busy, frame_start}), 32'(2'b10));
            end
        end
        step(1);
        check_val("b2b_col", 32'(collision), 32'd0);
        check_val("b2b_fc", 32'(frame_count), 32'd3);

        // Abort: second capture while in SEND1
        apply_reset();
        rand_inputs(10);
        latch_pulse = 1'b1;
        step(1);
        latch_pulse = 1'b0;
        step(1);
        rand_inputs(10);
        latch_pulse = 1'b1;
        step(1);
        latch_pulse = 1'b0;
        check_val("abort_restart", 32'({frame_start, collision}), 32'(2'b11));
        check_val("abort_w0", 32'(word0), 32'({cnt[0], adr[0]}));
        for (int k = 0; k < 4; k++) step(1);
        rand_inputs(10);
        latch_pulse = 1'b1;
        step(1);
        latch_pulse = 1'b0;
        for (int k = 0; k < 4; k++) step(1);
        check_val("abort_sticky", 32'(collision), 32'd1);

        // Reset during SEND2
        rand_inputs(10);
        latch_pulse = 1'b1;
        step(1);
        latch_pulse = 1'b0;
        step(1);
        step(1);
        reset = 1'b1;
        model_reset();
        #1;
        check_val("rst_busy", 32'({busy, vld0, vld1}), 32'd0);
        check_val("rst_fc", 32'(frame_count), 32'd0);
        check_val("rst_col", 32'(collision), 32'd0);
        latch_pulse = 1'b1;
        step(1);
        reset = 1'b0;
        latch_pulse = 1'b0;
        for (int k = 0; k < 3; k++) step(1);
        check_val("rst_noslots", 32'(busy), 32'd0);

        // Frame counter wrap
        apply_reset();
        latch_pulse = 1'b1;
        for (int k = 0; k < 4095; k++) begin
            rand_inputs(30);
            step(0);
        end
        check_val("wrap_pre", 32'(frame_count), 32'd4095);
        step(1);
        check_val("wrap_zero", 32'(frame_count), 32'd0);
        latch_pulse = 1'b0;

        // Random traffic with occasional resets
        apply_reset();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(199) == 0) begin
                apply_reset();
            end else begin
                rand_inputs(int'($urandom_range(60)));
                latch_pulse = ($urandom_range(4) == 0);
                step(1);
            end
        end
        latch_pulse = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
